frame_extreme: RTL

Streaming extremum tracker, parametrised successor of the team's fixed 3-bit two's-complement max comparator. It accepts a frame of WIDTH-bit samples over a valid/ready stream and tracks the running maximum or minimum. For each frame it reports the winning value, the index of its first occurrence, and the sample count. It sits between a sample source and a result consumer, with backpressure on both sides.

---
 rtl/frame_extreme_pkg.sv | 15 +
 rtl/frame_extreme_if.sv | 32 +++
 rtl/frame_extreme_cmp_ext.sv | 29 ++
 rtl/frame_extreme.sv | 127 ++++++++++++
 4 files changed

// File: rtl/frame_extreme_pkg.sv
// Shared types and constants for the streaming extremum tracker.
package frame_extreme_pkg;

    // Frame tracker control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Selects which extremum a frame tracks.
    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

endpackage : frame_extreme_pkg

// File: rtl/frame_extreme_if.sv
// Sample-in / result-out stream bundle for frame_extreme.
interface frame_extreme_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_LEN = 8
);
    localparam int unsigned IDXW = $clog2(FRAME_LEN);
    localparam int unsigned CNTW = $clog2(FRAME_LEN + 1);

    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [IDXW-1:0]  out_index;
    logic [CNTW-1:0]  out_count;

    // Tracker side: consumes samples, produces results.
    modport slave (
        input  mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_value, out_index, out_count
    );

    // Source/consumer side.
    modport master (
        output mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_value, out_index, out_count
    );

endinterface : frame_extreme_if

// File: rtl/frame_extreme_cmp_ext.sv
// Combinational "a strictly beats b" comparator for max or min tracking.
module cmp_ext
    import frame_extreme_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SIGNED = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             win
);

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;

    // Inverting the sign bit maps two's-complement order onto unsigned order,
    // so one magnitude compare serves both SIGNED settings.
    always_comb begin
        a_key = {a[WIDTH-1] ^ SIGNED, a[WIDTH-2:0]};
        b_key = {b[WIDTH-1] ^ SIGNED, b[WIDTH-2:0]};
        if (mode == MODE_MIN) begin
            win = (a_key < b_key);
        end else begin
            win = (a_key > b_key);
        end
    end

endmodule : cmp_ext

// File: rtl/frame_extreme.sv
// Streaming extremum tracker: running max/min, first-occurrence index and
// sample count per frame, with valid/ready on both sides.
module frame_extreme
    import frame_extreme_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_LEN = 8,
    parameter bit          SIGNED    = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    frame_extreme_if.slave bus
);

    localparam int unsigned IDXW = $clog2(FRAME_LEN);
    localparam int unsigned CNTW = $clog2(FRAME_LEN + 1);
    localparam logic [CNTW-1:0] LEN_C = CNTW'(FRAME_LEN);
    localparam logic [CNTW-1:0] ONE_C = CNTW'(1);

    state_t           state_q;
    logic             mode_q;
    logic [WIDTH-1:0] best_q;
    logic [IDXW-1:0]  best_idx_q;
    logic [CNTW-1:0]  cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_value_q;
    logic [IDXW-1:0]  out_index_q;
    logic [CNTW-1:0]  out_count_q;

    logic             accept;
    logic             win;
    logic [CNTW-1:0]  cnt_d;
    logic [WIDTH-1:0] best_d;
    logic [IDXW-1:0]  best_idx_d;
    logic             term_d;

    cmp_ext #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a    (bus.in_data),
        .b    (best_q),
        .mode (mode_q),
        .win  (win)
    );

    // Next best/count for an accepted non-first sample; ties keep the incumbent.
    always_comb begin
        accept     = bus.in_valid && in_ready_q;
        cnt_d      = cnt_q + ONE_C;
        best_d     = win ? bus.in_data : best_q;
        best_idx_d = win ? cnt_q[IDXW-1:0] : best_idx_q;
        term_d     = bus.in_last || (cnt_d == LEN_C);
    end

    // Frame FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_MAX;
            best_q      <= '0;
            best_idx_q  <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_index_q <= '0;
            out_count_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        best_q     <= bus.in_data;
                        best_idx_q <= '0;
                        cnt_q      <= ONE_C;
                        mode_q     <= bus.mode;
                        if (bus.in_last) begin
                            out_value_q <= bus.in_data;
                            out_index_q <= '0;
                            out_count_q <= ONE_C;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= HOLD;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        best_q     <= best_d;
                        best_idx_q <= best_idx_d;
                        cnt_q      <= cnt_d;
                        if (term_d) begin
                            out_value_q <= best_d;
                            out_index_q <= best_idx_d;
                            out_count_q <= cnt_d;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_value = out_value_q;
    assign bus.out_index = out_index_q;
    assign bus.out_count = out_count_q;

endmodule : frame_extreme
